// File: rtl/painterengine_gpu_memcpy_arbiter.sv
// Round-robin arbiter sharing one memcpy engine across NUM_REQ requesters.
// It starts each job by releasing the engine reset and returns a one-cycle done pulse with a status code.
module painterengine_gpu_memcpy_arbiter #(
  parameter int unsigned NUM_REQ        = 4,
  parameter logic [31:0] TIMEOUT_CYCLES = 32'd1000000,
  parameter int unsigned RESET_HOLD     = 2,
  localparam int unsigned IDX_W         = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
  input  logic                    i_wire_clock,
  input  logic                    i_wire_resetn,
  input  logic [NUM_REQ-1:0]      i_wire_req,
  input  logic [32*NUM_REQ-1:0]   i_wire_src_address,
  input  logic [32*NUM_REQ-1:0]   i_wire_dst_address,
  input  logic [32*NUM_REQ-1:0]   i_wire_length,
  output logic [NUM_REQ-1:0]      o_wire_done,
  output logic [2:0]              o_wire_status,
  output logic                    o_wire_busy,
  output logic [IDX_W-1:0]        o_wire_grant_id,
  output logic                    o_wire_memcpy_resetn,
  output logic [31:0]             o_wire_memcpy_source_address,
  output logic [31:0]             o_wire_memcpy_dest_address,
  output logic [31:0]             o_wire_memcpy_length,
  input  logic [31:0]             i_wire_memcpy_state
);

  typedef enum logic [2:0] {
    S_IDLE, S_GRANT, S_RUN, S_WAIT, S_COMPLETE, S_HOLD
  } state_t;

  localparam logic [31:0] TO_LAST   = TIMEOUT_CYCLES - 32'd1;
  localparam logic [31:0] HOLD_LAST = 32'(RESET_HOLD) - 32'd1;

  state_t               state_q;
  logic [IDX_W-1:0]     rr_ptr_q;
  logic [IDX_W-1:0]     grant_id_q;
  logic [31:0]          to_cnt_q;
  logic [31:0]          hold_q;
  logic [NUM_REQ-1:0]   done_q;
  logic [2:0]           status_q;
  logic                 busy_q;
  logic                 mc_resetn_q;
  logic [31:0]          src_q, dst_q, len_q;

  logic [31:0]          src_arr [NUM_REQ];
  logic [31:0]          dst_arr [NUM_REQ];
  logic [31:0]          len_arr [NUM_REQ];
  logic                 win_vld;
  logic [IDX_W-1:0]     win_idx;
  int                   scan_k;
  logic [7:0]           code;
  logic                 code_term;
  logic                 unused_state_hi;

  assign code            = i_wire_memcpy_state[7:0];
  assign unused_state_hi = ^i_wire_memcpy_state[31:8];
  // 8'h08..8'h0B are the terminal codes; their low two bits are the status.
  assign code_term       = (code[7:2] == 6'b000010);

  always_comb begin
    for (int k = 0; k < int'(NUM_REQ); k++) begin
      src_arr[k] = i_wire_src_address[32*k +: 32];
      dst_arr[k] = i_wire_dst_address[32*k +: 32];
      len_arr[k] = i_wire_length[32*k +: 32];
    end
  end

  // Scan downward so the candidate nearest rr_ptr is the last to overwrite.
  always_comb begin
    win_vld = 1'b0;
    win_idx = '0;
    scan_k  = 0;
    for (int i = int'(NUM_REQ) - 1; i >= 0; i--) begin
      scan_k = int'(rr_ptr_q) + i;
      if (scan_k >= int'(NUM_REQ)) scan_k = scan_k - int'(NUM_REQ);
      if (i_wire_req[scan_k[IDX_W-1:0]]) begin
        win_vld = 1'b1;
        win_idx = scan_k[IDX_W-1:0];
      end
    end
  end

  always_ff @(posedge i_wire_clock or negedge i_wire_resetn) begin
    if (!i_wire_resetn) begin
      state_q     <= S_IDLE;
      rr_ptr_q    <= '0;
      grant_id_q  <= '0;
      to_cnt_q    <= '0;
      hold_q      <= '0;
      done_q      <= '0;
      status_q    <= '0;
      busy_q      <= 1'b0;
      mc_resetn_q <= 1'b0;
      src_q       <= '0;
      dst_q       <= '0;
      len_q       <= '0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (win_vld) begin
            grant_id_q <= win_idx;
            src_q      <= src_arr[win_idx];
            dst_q      <= dst_arr[win_idx];
            len_q      <= len_arr[win_idx];
            busy_q     <= 1'b1;
            state_q    <= S_GRANT;
          end
        end
        S_GRANT: begin
          mc_resetn_q <= 1'b1;
          state_q     <= S_RUN;
        end
        S_RUN: begin
          to_cnt_q <= '0;
          state_q  <= S_WAIT;
        end
        S_WAIT: begin
          if (code_term || (TIMEOUT_CYCLES != 32'd0 && to_cnt_q == TO_LAST)) begin
            status_q    <= code_term ? {1'b0, code[1:0]} : 3'd4;
            done_q      <= {{(NUM_REQ-1){1'b0}}, 1'b1} << grant_id_q;
            mc_resetn_q <= 1'b0;
            state_q     <= S_COMPLETE;
          end else if (to_cnt_q != 32'hFFFF_FFFF) begin
            to_cnt_q <= to_cnt_q + 32'd1;
          end
        end
        S_COMPLETE: begin
          done_q   <= '0;
          status_q <= '0;
          busy_q   <= 1'b0;
          rr_ptr_q <= (grant_id_q == IDX_W'(NUM_REQ - 1)) ? '0 : grant_id_q + 1'b1;
          hold_q   <= HOLD_LAST;
          state_q  <= S_HOLD;
        end
        S_HOLD: begin
          if (hold_q == 32'd0) state_q <= S_IDLE;
          else                 hold_q  <= hold_q - 32'd1;
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign o_wire_done                  = done_q;
  assign o_wire_status                = status_q;
  assign o_wire_busy                  = busy_q;
  assign o_wire_grant_id              = grant_id_q;
  assign o_wire_memcpy_resetn         = mc_resetn_q;
  assign o_wire_memcpy_source_address = src_q;
  assign o_wire_memcpy_dest_address   = dst_q;
  assign o_wire_memcpy_length         = len_q;

endmodule

// File: tb/tb_painterengine_gpu_memcpy_arbiter.sv
// Directed bench: job table plus hand-written latency, timeout and reset sequences.
module tb_painterengine_gpu_memcpy_arbiter;

  logic         clk = 1'b0;
  logic         rstn = 1'b0;
  logic [3:0]   req_r = '0;
  logic [127:0] src_bus, dst_bus, len_bus;
  logic [3:0]   done;
  logic [2:0]   status;
  logic         busy;
  logic [1:0]   gid;
  logic         mc_rstn;
  logic [31:0]  mc_src, mc_dst, mc_len;
  logic [31:0]  eng_state = '0;
  logic [7:0]   eng_code = 8'h08;
  int           eng_delay = 3;
  int           eng_cnt = 0;

  logic [31:0] src_tab [4];
  logic [31:0] dst_tab [4];
  logic [31:0] len_tab [4];

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  assign src_bus = {src_tab[3], src_tab[2], src_tab[1], src_tab[0]};
  assign dst_bus = {dst_tab[3], dst_tab[2], dst_tab[1], dst_tab[0]};
  assign len_bus = {len_tab[3], len_tab[2], len_tab[1], len_tab[0]};

  painterengine_gpu_memcpy_arbiter #(
    .NUM_REQ(4), .TIMEOUT_CYCLES(32'd100), .RESET_HOLD(2)
  ) dut (
    .i_wire_clock(clk),
    .i_wire_resetn(rstn),
    .i_wire_req(req_r),
    .i_wire_src_address(src_bus),
    .i_wire_dst_address(dst_bus),
    .i_wire_length(len_bus),
    .o_wire_done(done),
    .o_wire_status(status),
    .o_wire_busy(busy),
    .o_wire_grant_id(gid),
    .o_wire_memcpy_resetn(mc_rstn),
    .o_wire_memcpy_source_address(mc_src),
    .o_wire_memcpy_dest_address(mc_dst),
    .o_wire_memcpy_length(mc_len),
    .i_wire_memcpy_state(eng_state)
  );

  // Engine model: idle while held in reset, busy code 8'h03, then eng_code after eng_delay cycles.
  always @(posedge clk) begin
    if (!mc_rstn) begin
      eng_cnt   <= 0;
      eng_state <= 32'h0;
    end else begin
      eng_cnt   <= eng_cnt + 1;
      eng_state <= (eng_cnt + 1 >= eng_delay) ? {24'h0, eng_code} : 32'h3;
    end
  end

  typedef struct {
    logic [3:0] req;
    logic [7:0] code;
    int         dly;
    int         exp_id;
    logic [2:0] exp_st;
  } vec_t;

  vec_t tab [12];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h, expected %h", nm, act, exp);
    end
  endtask

  task automatic wait_busy(output bit ok);
    ok = 1'b0;
    for (int c = 0; c < 50; c++) begin
      @(negedge clk);
      if (busy) begin ok = 1'b1; break; end
    end
  endtask

  task automatic wait_done(output bit ok);
    ok = 1'b0;
    for (int c = 0; c < 400; c++) begin
      @(negedge clk);
      if (done != 4'b0) begin ok = 1'b1; break; end
    end
  endtask

  task automatic start_job(input logic [3:0] rq, input logic [7:0] cd, input int dl, input int exp_id);
    bit ok;
    eng_code  = cd;
    eng_delay = dl;
    req_r     = rq;
    wait_busy(ok);
    chk("busy_wait", 32'(ok), 32'd1);
    chk("grant_id", 32'(gid), 32'(exp_id));
    chk("src_addr", mc_src, src_tab[exp_id]);
    chk("dst_addr", mc_dst, dst_tab[exp_id]);
    chk("length", mc_len, len_tab[exp_id]);
  endtask

  task automatic finish_job(input int exp_id, input logic [2:0] exp_st);
    bit ok;
    wait_done(ok);
    chk("done_wait", 32'(ok), 32'd1);
    chk("done_vec", 32'(done), 32'd1 << exp_id);
    chk("status", 32'(status), 32'(exp_st));
    chk("src_stable", mc_src, src_tab[exp_id]);
    chk("mc_rstn_complete", 32'(mc_rstn), 32'd0);
    req_r = '0;
    @(negedge clk);
    chk("done_one_cycle", 32'(done), 32'd0);
  endtask

  initial begin
    bit ok;
    int k;
    src_tab = '{32'h4000, 32'h5000, 32'h1000, 32'h6000};
    dst_tab = '{32'h8000, 32'h9000, 32'h2000, 32'hA000};
    len_tab = '{32'd5, 32'd7, 32'd16, 32'd0};

    tab[0]  = '{4'b1111, 8'h08, 3, 0, 3'd0};
    tab[1]  = '{4'b1111, 8'h08, 3, 1, 3'd0};
    tab[2]  = '{4'b1111, 8'h08, 3, 2, 3'd0};
    tab[3]  = '{4'b1111, 8'h08, 3, 3, 3'd0};
    tab[4]  = '{4'b1111, 8'h08, 3, 0, 3'd0};
    tab[5]  = '{4'b1111, 8'h08, 3, 1, 3'd0};
    tab[6]  = '{4'b1010, 8'h08, 5, 3, 3'd0};
    tab[7]  = '{4'b0010, 8'h08, 3, 1, 3'd0};
    tab[8]  = '{4'b0001, 8'h09, 3, 0, 3'd1};
    tab[9]  = '{4'b0001, 8'h0A, 3, 0, 3'd2};
    tab[10] = '{4'b0001, 8'h0B, 3, 0, 3'd3};
    tab[11] = '{4'b1000, 8'h08, 1, 3, 3'd0};

    // Reset state
    repeat (2) @(negedge clk);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_mc_rstn", 32'(mc_rstn), 32'd0);
    chk("rst_gid", 32'(gid), 32'd0);
    chk("rst_src", mc_src, 32'd0);
    rstn = 1'b1;
    @(negedge clk);
    chk("idle_busy", 32'(busy), 32'd0);

    // Single job with exact latency and reset-hold gap
    eng_code = 8'h08; eng_delay = 40;
    req_r = 4'b0100;
    @(negedge clk);
    chk("t1_grant_busy", 32'(busy), 32'd1);
    chk("t1_grant_id", 32'(gid), 32'd2);
    chk("t1_grant_mc_rstn", 32'(mc_rstn), 32'd0);
    @(negedge clk);
    chk("t1_run_mc_rstn", 32'(mc_rstn), 32'd1);
    chk("t1_src", mc_src, 32'h1000);
    chk("t1_dst", mc_dst, 32'h2000);
    chk("t1_len", mc_len, 32'd16);
    wait_done(ok);
    chk("t1_done_wait", 32'(ok), 32'd1);
    chk("t1_done_vec", 32'(done), 32'b0100);
    chk("t1_status", 32'(status), 32'd0);
    eng_delay = 3;
    req_r = 4'b1000;
    for (int c = 1; c <= 3; c++) begin
      @(negedge clk);
      chk("t1_gap_done", 32'(done), 32'd0);
      chk("t1_gap_busy", 32'(busy), 32'd0);
      chk("t1_gap_mc_rstn", 32'(mc_rstn), 32'd0);
    end
    @(negedge clk);
    chk("t1_next_busy", 32'(busy), 32'd1);
    chk("t1_next_gid", 32'(gid), 32'd3);
    finish_job(3, 3'd0);

    // Round-robin, contention, error codes, zero length
    for (int v = 0; v < 12; v++) begin
      start_job(tab[v].req, tab[v].code, tab[v].dly, tab[v].exp_id);
      finish_job(tab[v].exp_id, tab[v].exp_st);
    end

    // Watchdog: engine stuck at 8'h04
    eng_code = 8'h04; eng_delay = 0;
    req_r = 4'b0100;
    ok = 1'b0;
    for (int c = 0; c < 50; c++) begin
      @(negedge clk);
      if (mc_rstn) begin ok = 1'b1; break; end
    end
    chk("to_run_wait", 32'(ok), 32'd1);
    chk("to_gid", 32'(gid), 32'd2);
    k = 0;
    for (int c = 1; c <= 300; c++) begin
      @(negedge clk);
      if (done != 4'b0) begin k = c; break; end
    end
    chk("to_latency", 32'(k), 32'd101);
    chk("to_done_vec", 32'(done), 32'b0100);
    chk("to_status", 32'(status), 32'd4);
    chk("to_mc_rstn", 32'(mc_rstn), 32'd0);
    req_r = '0;
    @(negedge clk);
    chk("to_done_one_cycle", 32'(done), 32'd0);
    start_job(4'b0100, 8'h08, 3, 2);
    finish_job(2, 3'd0);

    // Asynchronous reset during WAIT, then rr_ptr restarts at 0
    start_job(4'b1000, 8'h04, 0, 3);
    repeat (10) @(negedge clk);
    #2 rstn = 1'b0;
    #1;
    chk("ar_mc_rstn", 32'(mc_rstn), 32'd0);
    chk("ar_busy", 32'(busy), 32'd0);
    chk("ar_done", 32'(done), 32'd0);
    chk("ar_gid", 32'(gid), 32'd0);
    req_r = '0;
    repeat (2) @(negedge clk);
    chk("ar_hold_done", 32'(done), 32'd0);
    rstn = 1'b1;
    start_job(4'b1010, 8'h08, 3, 1);
    finish_job(1, 3'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not complete");
    $fatal(1);
  end

endmodule

// File: doc/painterengine_gpu_memcpy_arbiter.md
Name: painterengine_gpu_memcpy_arbiter

Overview:
Shares one painterengine memcpy engine between NUM_REQ requesters, such as the rasterizer, blitter and host command path. It arbitrates requests round-robin, latches the winner's source, destination and length, and starts the engine by releasing its resetn. It then watches the engine state word for a terminal code and returns a one-cycle done pulse plus a status code to the owning requester. A watchdog aborts jobs that hang.

Parameters:
NUM_REQ, 4, number of requesters (2..8); index width IDX_W = clog2(NUM_REQ), minimum 1.
TIMEOUT_CYCLES, 32'd1000000, maximum cycles in WAIT before abort; 0 disables the watchdog.
RESET_HOLD, 2, cycles the engine is held in reset between jobs (minimum 1).

Ports:
i_wire_clock  in  1  clock
i_wire_resetn  in  1  reset; asynchronous, active-low
i_wire_req  in  NUM_REQ  request level per requester
i_wire_src_address  in  32*NUM_REQ  byte source address; requester k uses bits [32k+31:32k]
i_wire_dst_address  in  32*NUM_REQ  byte destination address, same packing
i_wire_length  in  32*NUM_REQ  length in 32-bit words, same packing
o_wire_done  out  NUM_REQ  one-cycle completion pulse, one-hot
o_wire_status  out  3  result code; valid only while any o_wire_done bit is 1
o_wire_busy  out  1  high from GRANT through COMPLETE
o_wire_grant_id  out  IDX_W  current or most recent owner
o_wire_memcpy_resetn  out  1  drives the engine's i_wire_resetn
o_wire_memcpy_source_address  out  32  engine source address
o_wire_memcpy_dest_address  out  32  engine destination address
o_wire_memcpy_length  out  32  engine length
i_wire_memcpy_state  in  32  engine o_wire_state; bits [7:0] are used

Behaviour:
- Reset values: every output 0. This includes memcpy_resetn=0, so the engine is held in reset. Also state=IDLE, rr_ptr=0, timeout counter=0, hold counter=0.
- States: IDLE, GRANT, RUN, WAIT, COMPLETE, HOLD.
- IDLE:
  - If req is non-zero, select the first set bit scanning upward from rr_ptr with wrap-around.
  - Register owner to grant_id. Latch that requester's src/dst/len into the memcpy_* outputs. Go to GRANT.
  - memcpy_resetn stays 0.
- GRANT: one cycle with memcpy_resetn=0 and busy=1. Next state RUN.
- RUN: drive memcpy_resetn=1, clear the timeout counter, go to WAIT. memcpy_resetn stays 1 through WAIT.
- WAIT: decode state[7:0]. Priority order, top first:
  - 8'h08 -> status 0 (OK)
  - 8'h09 -> status 1 (length error)
  - 8'h0A -> status 2 (reader error)
  - 8'h0B -> status 3 (writer error)
  - Any of the above goes to COMPLETE.
  - Otherwise, if TIMEOUT_CYCLES≠0 and counter == TIMEOUT_CYCLES-1, status 4 (timeout) and go to COMPLETE.
  - Otherwise increment the counter and stay. The counter saturates and never wraps.
  - Codes 8'h00..8'h07 are non-terminal. Any other value is also non-terminal and is left to the watchdog.
- COMPLETE, exactly one cycle:
  - done[owner]=1 and status valid.
  - memcpy_resetn=0; the abort takes effect immediately on timeout.
  - rr_ptr = owner+1, wrapping to 0 at NUM_REQ.
  - Load the hold counter, go to HOLD.
- HOLD: memcpy_resetn=0 for RESET_HOLD cycles, then IDLE. Requests are not sampled here.
- memcpy_* address and length outputs are stable from GRANT until the next grant; they change only in IDLE on a grant.
- Latency: req rises in IDLE at cycle t:
  - grant registered at t+1 (GRANT)
  - memcpy_resetn=1 at t+2 (RUN)
  - done pulses one cycle after WAIT samples a terminal code.
  - Minimum gap between done and the next GRANT is RESET_HOLD+1 cycles.
- Requester handshake:
  - Hold req=1 with stable parameters until the done pulse.
  - Drop req on the cycle after done. If req is still high when the arbiter next samples in IDLE, it counts as a new request.
  - Dropping req mid-job does not cancel the job; it completes, and done is still pulsed.
- Simultaneous requests: exactly one grant per IDLE cycle. The others wait; they are never lost while held.
- Fairness: with all requests held continuously, grants follow rr_ptr order, e.g. 0,1,2,3,0… for NUM_REQ=4. No requester waits more than NUM_REQ-1 jobs.
- Zero length: passed through unchanged. The engine's terminal code decides the status.
- Async reset mid-job: all outputs return to reset values immediately and the engine is forced into reset. No done pulse is issued for the aborted job.

Test Plan:
1. Single job: req[2]=1, src=0x1000, dst=0x2000, len=16; engine model returns 8'h08 after 40 cycles -> grant_id=2 at t+1, memcpy_resetn=1 at t+2, done=4'b0100 with status=0 for exactly one cycle, then memcpy_resetn=0 for 2 cycles.
2. Round-robin: req=4'b1111 held, rr_ptr=0, each job ends in 8'h08 -> grant order 0,1,2,3,0,1; each done is one-hot to the matching owner.
3. Contention: req=4'b1010 asserted in the same cycle with rr_ptr=2 -> requester 3 is granted first, then requester 1. The memcpy_* outputs carry requester 3's parameters throughout its job.
4. Errors: the engine reports 8'h09, 8'h0A and 8'h0B on successive jobs -> status 1, 2 and 3 respectively, each with a single done pulse.
5. Timeout: TIMEOUT_CYCLES=100, engine state stuck at 8'h04 -> done with status=4 exactly 100 cycles after entering WAIT. memcpy_resetn=0 in COMPLETE, and the next request is served normally.
6. Reset mid-job: assert resetn=0 during WAIT -> memcpy_resetn, busy and done all read 0 asynchronously. After release with req[1]=1, requester 1 is granted with rr_ptr=0 scanning.
